alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 111 +++++++++++
 tb/tb_alu_result_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: small FIFO that tags each selected ALU result with its op select,
// derives status flags at push time, and keeps pop statistics for the consumer side.
module alu_result_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             E,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] X,
  input  logic             CI,
  input  logic             VI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] Q,
  output logic [2:0]       OP,
  output logic             FZ,
  output logic             FN,
  output logic             FC,
  output logic             FV,
  input  logic             CLR,
  output logic             OVF_STICKY,
  output logic [7:0]       POP_CNT
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  // Entry layout: {op[2:0], fz, fn, fc, fv, x[WIDTH-1:0]}
  localparam int unsigned ENT_W = WIDTH + 7;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] head, head_next, in_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_next, rd_next, rd_inc;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_entry = {S, (X == '0), X[WIDTH-1], CI, VI, X};
  assign push     = IN_VALID & E & IN_READY;
  assign pop      = OUT_VALID & OUT_READY;
  assign rd_inc   = ptr_inc(rd_ptr);

  // Next occupancy/pointers and the entry that will sit at the head after this edge
  always_comb begin
    cnt_next  = cnt;
    wr_next   = wr_ptr;
    rd_next   = rd_ptr;
    head_next = head;
    if (push) wr_next = ptr_inc(wr_ptr);
    if (pop)  rd_next = rd_inc;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CNT_W'(1);
      2'b01:   cnt_next = cnt - CNT_W'(1);
      default: cnt_next = cnt;
    endcase
    if (cnt_next == '0) begin
      head_next = '0;
    end else if (pop) begin
      // With one entry left, a surviving head can only be the one pushed this edge
      head_next = (cnt == CNT_W'(1)) ? in_entry : mem[rd_inc];
    end else if (cnt == '0) begin
      head_next = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head       <= '0;
      OUT_VALID  <= 1'b0;
      IN_READY   <= 1'b1;
      POP_CNT    <= '0;
      OVF_STICKY <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      head      <= head_next;
      OUT_VALID <= (cnt_next != '0);
      IN_READY  <= (cnt_next < CNT_W'(DEPTH));
      // Clear wins over a same-edge pop update
      if (CLR) begin
        POP_CNT    <= '0;
        OVF_STICKY <= 1'b0;
      end else if (pop) begin
        POP_CNT <= POP_CNT + 8'd1;
        if (FV) OVF_STICKY <= 1'b1;
      end
    end
  end

  assign Q  = head[WIDTH-1:0];
  assign FV = head[WIDTH];
  assign FC = head[WIDTH+1];
  assign FN = head[WIDTH+2];
  assign FZ = head[WIDTH+3];
  assign OP = head[WIDTH+6:WIDTH+4];

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model checked every
// cycle, plus hand-computed literal checks for the directed scenarios.
module tb_alu_result_stage;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             E, CI, VI, IN_VALID, OUT_READY, CLR;
  logic [2:0]       S;
  logic [WIDTH-1:0] X;
  logic             IN_READY, OUT_VALID, FZ, FN, FC, FV, OVF_STICKY;
  logic [WIDTH-1:0] Q;
  logic [2:0]       OP;
  logic [7:0]       POP_CNT;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .E(E), .S(S), .X(X), .CI(CI), .VI(VI),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .Q(Q), .OP(OP), .FZ(FZ), .FN(FN), .FC(FC), .FV(FV),
    .CLR(CLR), .OVF_STICKY(OVF_STICKY), .POP_CNT(POP_CNT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [2:0]       s;
    logic             ci;
    logic             vi;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] m_cnt = '0;
  logic       m_ovf = 1'b0;

  // Reference model: a plain queue with the handshake rules applied at each edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_cnt = '0;
      m_ovf = 1'b0;
    end else begin
      bit   do_push, do_pop;
      ent_t popped;
      do_push = IN_VALID && E && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && OUT_READY;
      popped  = '0;
      if (do_pop) popped = mq.pop_front();
      if (do_push) mq.push_back('{x: X, s: S, ci: CI, vi: VI});
      if (CLR) begin
        m_cnt = '0;
        m_ovf = 1'b0;
      end else if (do_pop) begin
        m_cnt = m_cnt + 8'd1;
        if (popped.vi) m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      ent_t h;
      h = (mq.size() > 0) ? mq[0] : '0;
      chk("m_in_ready", 32'(IN_READY), 32'(mq.size() < DEPTH));
      chk("m_out_valid", 32'(OUT_VALID), 32'(mq.size() > 0));
      chk("m_q", 32'(Q), 32'(h.x));
      chk("m_op", 32'(OP), 32'(h.s));
      chk("m_fz", 32'(FZ), 32'((mq.size() > 0) && (h.x == 0)));
      chk("m_fn", 32'(FN), 32'(h.x[WIDTH-1]));
      chk("m_fc", 32'(FC), 32'(h.ci));
      chk("m_fv", 32'(FV), 32'(h.vi));
      chk("m_pop_cnt", 32'(POP_CNT), 32'(m_cnt));
      chk("m_ovf", 32'(OVF_STICKY), 32'(m_ovf));
    end
  end

  task automatic step(input logic iv, input logic en, input logic [2:0] s,
                      input logic [WIDTH-1:0] x, input logic ci, input logic vi,
                      input logic ordy, input logic clr);
    IN_VALID = iv; E = en; S = s; X = x; CI = ci; VI = vi; OUT_READY = ordy; CLR = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    IN_VALID = 1'b0; E = 1'b0; S = '0; X = '0; CI = 1'b0; VI = 1'b0;
    OUT_READY = 1'b0; CLR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_pop_cnt", 32'(POP_CNT), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check_en = 1'b1;
    @(posedge clk);
    #1;

    // Zero result tagged with op 2
    step(1, 1, 3'd2, 16'h0000, 0, 0, 0, 0);
    chk("zero_valid", 32'(OUT_VALID), 32'd1);
    chk("zero_q", 32'(Q), 32'd0);
    chk("zero_op", 32'(OP), 32'd2);
    chk("zero_fz", 32'(FZ), 32'd1);
    chk("zero_fn", 32'(FN), 32'd0);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 0);
    chk("zero_popped", 32'(OUT_VALID), 32'd0);
    chk("zero_popcnt", 32'(POP_CNT), 32'd1);

    // Fill to depth, third offer ignored, FIFO order
    step(1, 1, 3'd1, 16'h8001, 0, 0, 0, 0);
    step(1, 1, 3'd3, 16'h0005, 0, 0, 0, 0);
    chk("full_in_ready", 32'(IN_READY), 32'd0);
    step(1, 1, 3'd4, 16'h7777, 0, 0, 0, 0);
    chk("full_head_q", 32'(Q), 32'h8001);
    chk("full_head_fn", 32'(FN), 32'd1);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 0);
    chk("pop1_q", 32'(Q), 32'h0005);
    chk("pop1_fn", 32'(FN), 32'd0);
    chk("pop1_op", 32'(OP), 32'd3);
    chk("pop1_in_ready", 32'(IN_READY), 32'd1);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 0);
    chk("pop2_valid", 32'(OUT_VALID), 32'd0);
    chk("pop2_cnt", 32'(POP_CNT), 32'd3);

    // Simultaneous push and pop at occupancy 1
    step(1, 1, 3'd5, 16'h00AA, 0, 0, 0, 0);
    step(1, 1, 3'd6, 16'h1234, 0, 0, 1, 0);
    chk("pp_valid", 32'(OUT_VALID), 32'd1);
    chk("pp_q", 32'(Q), 32'h1234);
    chk("pp_cnt", 32'(POP_CNT), 32'd4);
    chk("pp_in_ready", 32'(IN_READY), 32'd1);

    // Push offered while full with a pop: pop happens, push refused
    step(1, 1, 3'd7, 16'h4321, 0, 0, 0, 0);
    step(1, 1, 3'd0, 16'hBEEF, 0, 0, 1, 0);
    chk("fullpp_q", 32'(Q), 32'h4321);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 0);
    chk("fullpp_empty", 32'(OUT_VALID), 32'd0);
    chk("fullpp_cnt", 32'(POP_CNT), 32'd6);

    // Overflow sticky and clear
    step(1, 1, 3'd1, 16'h7FFF, 1, 1, 0, 0);
    chk("ovf_fv", 32'(FV), 32'd1);
    chk("ovf_fc", 32'(FC), 32'd1);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 0);
    chk("ovf_sticky", 32'(OVF_STICKY), 32'd1);
    chk("ovf_cnt", 32'(POP_CNT), 32'd7);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 0, 1);
    chk("clr_sticky", 32'(OVF_STICKY), 32'd0);
    chk("clr_cnt", 32'(POP_CNT), 32'd0);

    // Clear overrides a same-edge overflowing pop
    step(1, 1, 3'd2, 16'h8000, 0, 1, 0, 0);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 1);
    chk("clrpop_sticky", 32'(OVF_STICKY), 32'd0);
    chk("clrpop_cnt", 32'(POP_CNT), 32'd0);
    chk("clrpop_empty", 32'(OUT_VALID), 32'd0);

    // 256 pops wrap the counter back to 0
    step(1, 1, 3'd3, 16'h0001, 0, 0, 0, 0);
    for (int i = 0; i < 255; i++) step(1, 1, 3'(i), 16'(i + 2), 0, 0, 1, 0);
    chk("wrap_cnt_255", 32'(POP_CNT), 32'd255);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 0);
    chk("wrap_cnt", 32'(POP_CNT), 32'd0);
    chk("wrap_empty", 32'(OUT_VALID), 32'd0);

    // Disabled stage ignores offered results
    step(1, 0, 3'd4, 16'h5555, 0, 0, 0, 0);
    step(1, 0, 3'd4, 16'h5555, 0, 0, 0, 0);
    chk("en0_valid", 32'(OUT_VALID), 32'd0);

    // Asynchronous reset with two entries stored
    step(1, 1, 3'd1, 16'h0A0A, 0, 0, 0, 0);
    step(1, 1, 3'd2, 16'h0B0B, 0, 0, 0, 0);
    chk("pre_rst_full", 32'(IN_READY), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(OUT_VALID), 32'd0);
    chk("arst_q", 32'(Q), 32'd0);
    chk("arst_in_ready", 32'(IN_READY), 32'd1);
    step(1, 1, 3'd3, 16'h0C0C, 0, 0, 1, 0);
    chk("rst_edge_nopush", 32'(OUT_VALID), 32'd0);
    #3 reset_n = 1'b1;
    step(1, 1, 3'd5, 16'h00F0, 0, 0, 0, 0);
    chk("first_push_valid", 32'(OUT_VALID), 32'd1);
    chk("first_push_q", 32'(Q), 32'h00F0);
    chk("first_push_op", 32'(OP), 32'd5);
    step(0, 1, 3'd0, 16'h0000, 0, 0, 1, 0);
    chk("final_empty", 32'(OUT_VALID), 32'd0);
    chk("final_cnt", 32'(POP_CNT), 32'd1);

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
